// File: rtl/key_writer.sv
// Password enrollment controller: captures four digits while the lock is open,
// then writes them as an atomic burst into consecutive register-file slots.
module key_writer #(
  parameter logic [4:0]  BASE_ADDR = 5'd8,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        unlock,
  input  logic        enroll_req,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [3:0][3:0]   buf_q, buf_d;

  logic              we_d;
  logic [4:0]        waddr_d;
  logic [31:0]       wdata_d;
  logic              busy_d;
  logic              done_d;
  logic              error_d;

  // State, counters and digit buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      tcnt_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state they describe once registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        if (enroll_req) begin
          if (unlock) begin
            state_d = CAPTURE;
            cnt_d   = 2'd0;
            tcnt_d  = '0;
          end else begin
            state_d = ERR;
          end
        end
      end

      CAPTURE: begin
        // Losing the unlock beats a digit arriving in the same cycle.
        if (!unlock) begin
          state_d = ERR;
          buf_d   = '0;
          cnt_d   = 2'd0;
          tcnt_d  = '0;
        end else if (digit_valid) begin
          buf_d[cnt_q] = digit;
          cnt_d        = cnt_q + 2'd1;
          tcnt_d       = '0;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            idx_d   = 2'd0;
          end
        end else if ((32'(tcnt_q) + 32'd1) >= TIMEOUT) begin
          state_d = ERR;
          buf_d   = '0;
          cnt_d   = 2'd0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      WRITE: begin
        if (idx_q == 2'd3) begin
          state_d = DONE;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        buf_d   = '0;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state
  always_comb begin
    we_d    = (state_d == WRITE);
    waddr_d = 5'd0;
    wdata_d = 32'd0;
    if (we_d) begin
      waddr_d = BASE_ADDR + {3'b000, idx_d};
      wdata_d = {28'd0, buf_d[idx_d]};
    end
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we    <= 1'b0;
      reg_waddr <= 5'd0;
      reg_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      reg_we    <= we_d;
      reg_waddr <= waddr_d;
      reg_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_key_writer.sv
// Bench for key_writer: two instances (default base and a wrapping base) driven
// with directed and random stimulus, checked against an event-queue model.
module tb_key_writer;

  localparam int unsigned TO     = 5;
  localparam int unsigned BASE_A = 8;
  localparam int unsigned BASE_B = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        unlock;
  logic        enroll_req;
  logic [3:0]  digit;
  logic        digit_valid;

  logic        a_we, a_busy, a_done, a_error;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_we, b_busy, b_done, b_error;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;

  key_writer #(.BASE_ADDR(5'(BASE_A)), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .unlock(unlock), .enroll_req(enroll_req),
    .digit(digit), .digit_valid(digit_valid),
    .reg_we(a_we), .reg_waddr(a_waddr), .reg_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  key_writer #(.BASE_ADDR(5'(BASE_B)), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .unlock(unlock), .enroll_req(enroll_req),
    .digit(digit), .digit_valid(digit_valid),
    .reg_we(b_we), .reg_waddr(b_waddr), .reg_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  always #5 clk = ~clk;

  // One entry per output cycle the block owes us once a request is resolved.
  typedef struct {
    bit          we;
    int unsigned idx;
    int unsigned data;
    bit          done;
    bit          err;
  } ev_t;

  ev_t         pend[$];
  ev_t         cur;
  bit          capturing;
  int unsigned digs[$];
  int unsigned idle_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic ev_t mk_ev(bit we, int unsigned idx, int unsigned data, bit dn, bit er);
    ev_t e;
    e.we = we; e.idx = idx; e.data = data; e.done = dn; e.err = er;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    digs.delete();
    cur       = mk_ev(0, 0, 0, 0, 0);
    capturing = 0;
    idle_cnt  = 0;
  endtask

  // Applies the inputs seen at one rising edge to the model.
  task automatic model_edge();
    if (cur.we || cur.done || cur.err) begin
      // burst / pulse in progress: inputs have no effect
    end else if (capturing) begin
      if (!unlock) begin
        capturing = 0;
        pend.push_back(mk_ev(0, 0, 0, 0, 1));
      end else if (digit_valid) begin
        digs.push_back(int'(digit));
        idle_cnt = 0;
        if (digs.size() == 4) begin
          capturing = 0;
          for (int i = 0; i < 4; i++) pend.push_back(mk_ev(1, i, digs[i], 0, 0));
          pend.push_back(mk_ev(0, 0, 0, 1, 0));
        end
      end else begin
        idle_cnt++;
        if (idle_cnt >= TO) begin
          capturing = 0;
          pend.push_back(mk_ev(0, 0, 0, 0, 1));
        end
      end
    end else if (enroll_req) begin
      if (unlock) begin
        capturing = 1;
        digs.delete();
        idle_cnt = 0;
      end else begin
        pend.push_back(mk_ev(0, 0, 0, 0, 1));
      end
    end
    if (pend.size() > 0) cur = pend.pop_front();
    else                 cur = mk_ev(0, 0, 0, 0, 0);
  endtask

  task automatic check_outputs(input string tag);
    bit          exp_busy;
    int unsigned ea, eb, ed;
    exp_busy = capturing || cur.we || cur.done || cur.err;
    ea = cur.we ? (BASE_A + cur.idx) % 32 : 0;
    eb = cur.we ? (BASE_B + cur.idx) % 32 : 0;
    ed = cur.we ? cur.data : 0;
    chk({tag, ".a.we"},    32'(a_we),    32'(cur.we));
    chk({tag, ".a.addr"},  32'(a_waddr), ea);
    chk({tag, ".a.data"},  a_wdata,      ed);
    chk({tag, ".a.busy"},  32'(a_busy),  32'(exp_busy));
    chk({tag, ".a.done"},  32'(a_done),  32'(cur.done));
    chk({tag, ".a.err"},   32'(a_error), 32'(cur.err));
    chk({tag, ".b.we"},    32'(b_we),    32'(cur.we));
    chk({tag, ".b.addr"},  32'(b_waddr), eb);
    chk({tag, ".b.data"},  b_wdata,      ed);
    chk({tag, ".b.busy"},  32'(b_busy),  32'(exp_busy));
    chk({tag, ".b.done"},  32'(b_done),  32'(cur.done));
    chk({tag, ".b.err"},   32'(b_error), 32'(cur.err));
  endtask

  task automatic step(input bit e, input bit u, input bit v, input logic [3:0] d, input string tag);
    enroll_req  = e;
    unlock      = u;
    digit_valid = v;
    digit       = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 1, 0, 4'd0, tag);
  endtask

  initial begin
    rst = 1'b1; unlock = 1'b0; enroll_req = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    check_outputs("reset_edge");
    rst = 1'b0;

    // Basic enrollment 3,7,1,9
    step(1, 1, 0, 4'd0, "basic_enroll");
    step(0, 1, 1, 4'd3, "basic_d0");
    step(0, 1, 1, 4'd7, "basic_d1");
    step(0, 1, 1, 4'd1, "basic_d2");
    step(0, 1, 1, 4'd9, "basic_d3");
    idle_steps(6, "basic_tail");

    // Enrollment refused while locked
    step(1, 0, 0, 4'd0, "locked_enroll");
    step(0, 0, 1, 4'd5, "locked_after");
    idle_steps(2, "locked_tail");

    // Unlock drops together with the third digit, then a fresh enrollment
    step(1, 1, 0, 4'd0, "abort_enroll");
    step(0, 1, 1, 4'd4, "abort_d0");
    step(0, 1, 1, 4'd5, "abort_d1");
    step(0, 0, 1, 4'd6, "abort_d2");
    idle_steps(2, "abort_gap");
    step(1, 1, 0, 4'd0, "fresh_enroll");
    step(0, 1, 1, 4'd12, "fresh_d0");
    step(0, 1, 1, 4'd13, "fresh_d1");
    step(0, 1, 1, 4'd14, "fresh_d2");
    step(0, 1, 1, 4'd15, "fresh_d3");
    idle_steps(6, "fresh_tail");

    // Timeout expires after five quiet cycles
    step(1, 1, 0, 4'd0, "to_enroll");
    step(0, 1, 1, 4'd2, "to_d0");
    idle_steps(5, "to_quiet");
    idle_steps(2, "to_tail");

    // Digit on the fifth quiet cycle is still accepted
    step(1, 1, 0, 4'd0, "tok_enroll");
    step(0, 1, 1, 4'd6, "tok_d0");
    idle_steps(4, "tok_quiet");
    step(0, 1, 1, 4'd8, "tok_d1");
    step(0, 1, 1, 4'd10, "tok_d2");
    step(0, 1, 1, 4'd11, "tok_d3");
    idle_steps(6, "tok_tail");

    // Inputs during the burst have no effect
    step(1, 1, 0, 4'd0, "atom_enroll");
    step(0, 1, 1, 4'd1, "atom_d0");
    step(0, 1, 1, 4'd2, "atom_d1");
    step(0, 1, 1, 4'd3, "atom_d2");
    step(0, 1, 1, 4'd4, "atom_d3");
    step(1, 0, 1, 4'd9, "atom_w1");
    step(0, 0, 0, 4'd0, "atom_w2");
    step(1, 1, 1, 4'd7, "atom_w3");
    step(0, 0, 0, 4'd0, "atom_done");
    idle_steps(3, "atom_tail");

    // Reset after the second write strobe
    step(1, 1, 0, 4'd0, "rw_enroll");
    step(0, 1, 1, 4'd5, "rw_d0");
    step(0, 1, 1, 4'd6, "rw_d1");
    step(0, 1, 1, 4'd7, "rw_d2");
    step(0, 1, 1, 4'd8, "rw_d3");
    step(0, 1, 0, 4'd0, "rw_w1");
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rw_async");
    @(posedge clk); #1;
    check_outputs("rw_held");
    rst = 1'b0;
    idle_steps(6, "rw_after");

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), "rand");
    idle_steps(8, "rand_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_writer.md
KEY_WRITER -- requirements
Module: key_writer

Interface
REQ-001 Parameter BASE_ADDR, default 5'd8, is the register-file address of password digit 0; digits 1-3 go to BASE_ADDR+1..+3.
REQ-002 Parameter TIMEOUT, default 1000, is the maximum number of clk cycles allowed between accepted digits while capturing.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 unlock  input  1  high while the lock reports unlocked; gates enrollment.
REQ-006 enroll_req  input  1  single-cycle request to program a new 4-digit password.
REQ-007 digit  input  4  password digit value.
REQ-008 digit_valid  input  1  qualifies digit for one cycle.
REQ-009 reg_we  output  1  register-file write enable.
REQ-010 reg_waddr  output  5  register-file write address.
REQ-011 reg_wdata  output  32  register-file write data, {28'b0, digit}.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on successful programming.
REQ-014 error  output  1  one-cycle pulse on rejected or aborted enrollment.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE, WRITE, DONE, ERR.
REQ-016 IDLE: enroll_req=1 with unlock=1 -> CAPTURE, digit count cleared, timeout counter cleared.
REQ-017 IDLE: enroll_req=1 with unlock=0 -> ERR; no digits captured, no writes.
REQ-018 IDLE: digit_valid ignored; reg_we=0.
REQ-019 CAPTURE: each cycle with digit_valid=1 stores digit into buffer slot [count], increments 2-bit count, clears timeout counter.
REQ-020 CAPTURE: the digit that brings the accepted count to 4 -> WRITE, write index cleared.
REQ-021 CAPTURE: enroll_req ignored (no restart).
REQ-022 CAPTURE: unlock=0 in any cycle -> ERR, buffer discarded; abort takes priority over a simultaneous digit_valid.
REQ-023 CAPTURE: timeout counter increments each cycle without digit_valid; reaching TIMEOUT -> ERR; digit_valid in the same cycle takes priority and clears the counter.
REQ-024 WRITE: reg_we=1 for exactly 4 consecutive cycles, reg_waddr=BASE_ADDR+index, reg_wdata={28'b0, buffer[index]}, index 0..3 ascending.
REQ-025 WRITE: unlock, enroll_req and digit_valid ignored; the 4-write burst is atomic.
REQ-026 After write index 3 -> DONE; DONE lasts one cycle with done=1, then -> IDLE.
REQ-027 ERR lasts one cycle with error=1, then -> IDLE.
REQ-028 reg_we, done and error SHALL never be high simultaneously; reg_waddr and reg_wdata SHALL be 0 whenever reg_we=0.
REQ-029 Latency: fourth digit sampled at edge N -> writes in the cycles following edges N..N+3, done high after edge N+4, IDLE after edge N+5.
REQ-030 The address sum BASE_ADDR+index SHALL be 5-bit and wrap modulo 32.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, reg_we=0, reg_waddr=0, reg_wdata=0, busy=0, done=0, error=0, buffer, count, index and timeout counter all 0.
REQ-032 Reset asserted mid-WRITE SHALL abort the burst with no further write strobes and no done pulse.
REQ-033 After rst deasserts, the block SHALL wait in IDLE for a new enroll_req.

Verification
REQ-034 unlock=1, enroll_req, digits 3,7,1,9 on consecutive cycles -> writes (8,3),(9,7),(10,1),(11,9) on 4 consecutive cycles, then done pulse, busy low afterward.
REQ-035 unlock=0, enroll_req -> error pulse on the next cycle, reg_we never asserted.
REQ-036 Enroll, 2 digits, unlock drops in the same cycle as the 3rd digit_valid -> error pulse, no writes; a fresh enroll then writes only new digits.
REQ-037 Enroll with TIMEOUT=5, 1 digit, then idle 5 cycles -> error pulse; digit arriving on cycle 5 instead -> accepted, no error.
REQ-038 During the WRITE burst, toggle unlock low and pulse enroll_req -> all 4 writes and done still occur unchanged.
REQ-039 rst asserted after the 2nd write strobe -> outputs zero immediately, addresses 10 and 11 never written, no done.
